// File: rtl/hack_mmio_pkg.sv
// Shared constants and address decode for the Hack data-memory responder.
package hack_mmio_pkg;

   localparam logic [14:0] SCREEN_BASE = 15'd16384;
   localparam logic [14:0] KBD_ADDR    = 15'd24576;
   localparam logic [14:0] STAT_ADDR   = 15'd24577;

   // Status word bit positions
   localparam int STAT_KBD_NE    = 0;
   localparam int STAT_SCR_EMPTY = 1;
   localparam int STAT_SCR_FULL  = 2;
   localparam int STAT_SCR_OVF   = 3;
   localparam int STAT_KBD_OVF   = 4;

   // Screen FIFO entry: {word address[12:0], pixel word[15:0]}
   localparam int SCR_ENTRY_W = 29;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_SCREEN,
      REG_KBD,
      REG_STAT,
      REG_NONE
   } region_e;

   function automatic region_e decode(input logic [14:0] addr);
      region_e r;
      if (addr < SCREEN_BASE)     r = REG_RAM;
      else if (addr < KBD_ADDR)   r = REG_SCREEN;
      else if (addr == KBD_ADDR)  r = REG_KBD;
      else if (addr == STAT_ADDR) r = REG_STAT;
      else                        r = REG_NONE;
      return r;
   endfunction

endpackage

// File: rtl/hack_fifo.sv
// Synchronous in-order FIFO. A push into a full FIFO is still accepted when a
// pop happens in the same cycle; a pop on an empty FIFO is ignored.
// The head reads as zero while empty so consumers see a clean idle value.
module hack_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             accept_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_pop;

   assign empty_o  = (count == '0);
   assign full_o   = (count == FULL_CNT);
   assign do_pop   = pop_i & ~empty_o;
   assign accept_o = push_i & (~full_o | do_pop);
   assign head_o   = empty_o ? '0 : mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk_i) begin
      if (accept_o) mem[wr_ptr] <= data_i;
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept_o) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({accept_o, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hack_mmio.sv
// Hack CPU data-memory responder: decodes RAM / SCREEN / KBD / STAT, buffers
// screen writes toward the framebuffer and queues keyboard scan codes.
module hack_mmio
   import hack_mmio_pkg::*;
#(
   parameter int KBD_DEPTH = 4,
   parameter int SCR_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        load_i,
   input  logic [14:0] addr_i,
   input  logic [15:0] data_i,
   output logic [15:0] data_o,
   output logic        ram_load_o,
   input  logic [15:0] ram_data_i,
   output logic [12:0] scr_raddr_o,
   input  logic [15:0] scr_rdata_i,
   output logic        scr_valid_o,
   input  logic        scr_ready_i,
   output logic [12:0] scr_addr_o,
   output logic [15:0] scr_data_o,
   input  logic        kbd_valid_i,
   input  logic [15:0] kbd_code_i
);

   region_e                region;
   logic                   kbd_pop;
   logic [15:0]            kbd_head;
   logic                   kbd_full_unused;
   logic                   kbd_empty;
   logic                   kbd_accept;
   logic                   scr_push;
   logic [SCR_ENTRY_W-1:0] scr_head;
   logic                   scr_full;
   logic                   scr_empty;
   logic                   scr_accept;
   logic                   stat_wr;
   logic                   kbd_ovf;
   logic                   scr_ovf;
   logic [15:0]            status;

   assign region      = decode(addr_i);
   assign ram_load_o  = load_i & ~addr_i[14];
   assign scr_raddr_o = addr_i[12:0];
   assign kbd_pop     = load_i & (region == REG_KBD);
   assign scr_push    = load_i & (region == REG_SCREEN);
   assign stat_wr     = load_i & (region == REG_STAT);

   hack_fifo #(.WIDTH(16), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .push_i   (kbd_valid_i),
      .pop_i    (kbd_pop),
      .data_i   (kbd_code_i),
      .head_o   (kbd_head),
      .full_o   (kbd_full_unused),
      .empty_o  (kbd_empty),
      .accept_o (kbd_accept)
   );

   hack_fifo #(.WIDTH(SCR_ENTRY_W), .DEPTH(SCR_DEPTH)) u_scr_fifo (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .push_i   (scr_push),
      .pop_i    (scr_ready_i),
      .data_i   ({addr_i[12:0], data_i}),
      .head_o   (scr_head),
      .full_o   (scr_full),
      .empty_o  (scr_empty),
      .accept_o (scr_accept)
   );

   assign scr_valid_o = ~scr_empty;
   assign scr_addr_o  = scr_head[SCR_ENTRY_W-1:16];
   assign scr_data_o  = scr_head[15:0];

   // Sticky overflow flags: a new drop in the same cycle beats a W1C clear.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         kbd_ovf <= 1'b0;
         scr_ovf <= 1'b0;
      end else begin
         kbd_ovf <= (kbd_valid_i & ~kbd_accept) |
                    (kbd_ovf & ~(stat_wr & data_i[STAT_KBD_OVF]));
         scr_ovf <= (scr_push & ~scr_accept) |
                    (scr_ovf & ~(stat_wr & data_i[STAT_SCR_OVF]));
      end
   end

   // Assemble the status word from live FIFO state and sticky flags.
   always_comb begin
      status                 = '0;
      status[STAT_KBD_NE]    = ~kbd_empty;
      status[STAT_SCR_EMPTY] = scr_empty;
      status[STAT_SCR_FULL]  = scr_full;
      status[STAT_SCR_OVF]   = scr_ovf;
      status[STAT_KBD_OVF]   = kbd_ovf;
   end

   // Zero-latency read mux, like Hack RAM.
   always_comb begin
      data_o = '0;
      case (region)
         REG_RAM:    data_o = ram_data_i;
         REG_SCREEN: data_o = scr_rdata_i;
         REG_KBD:    data_o = kbd_head;
         REG_STAT:   data_o = status;
         default:    data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_hack_mmio.sv
// Bench for hack_mmio: directed vector table, a mid-drain reset sequence and
// randomized traffic, all checked against a queue-based model.
module tb_hack_mmio;

   localparam int KBD  = 24576;
   localparam int STAT = 24577;
   localparam int HOLE = 30000;
   localparam int SCR  = 16384;
   localparam int DEP  = 4;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        load_i;
   logic [14:0] addr_i;
   logic [15:0] data_i;
   logic [15:0] data_o;
   logic        ram_load_o;
   logic [15:0] ram_data_i;
   logic [12:0] scr_raddr_o;
   logic [15:0] scr_rdata_i;
   logic        scr_valid_o;
   logic        scr_ready_i;
   logic [12:0] scr_addr_o;
   logic [15:0] scr_data_o;
   logic        kbd_valid_i;
   logic [15:0] kbd_code_i;

   int n_cmp = 0;
   int n_err = 0;

   // Model state
   logic [15:0] kq[$];
   logic [28:0] sq[$];
   bit          kovf;
   bit          sovf;

   always #5 clk_i = ~clk_i;

   // External RAM and framebuffer readback are address-derived patterns.
   assign ram_data_i  = {1'b0, addr_i} ^ 16'hC3C3;
   assign scr_rdata_i = {3'b000, addr_i[12:0]} ^ 16'h5A5A;

   hack_mmio #(.KBD_DEPTH(DEP), .SCR_DEPTH(DEP)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .load_i      (load_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .ram_load_o  (ram_load_o),
      .ram_data_i  (ram_data_i),
      .scr_raddr_o (scr_raddr_o),
      .scr_rdata_i (scr_rdata_i),
      .scr_valid_o (scr_valid_o),
      .scr_ready_i (scr_ready_i),
      .scr_addr_o  (scr_addr_o),
      .scr_data_o  (scr_data_o),
      .kbd_valid_i (kbd_valid_i),
      .kbd_code_i  (kbd_code_i)
   );

   typedef struct {
      bit          ld;
      int          a;
      int          d;
      bit          kv;
      int          kc;
      bit          rdy;
      logic [15:0] exp_d;
      bit          exp_v;
      logic [12:0] exp_sa;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit ld, int a, int d, bit kv, int kc, bit rdy,
                               int ed, bit ev, int esa, string nm);
      vec_t v;
      v.ld = ld; v.a = a; v.d = d; v.kv = kv; v.kc = kc; v.rdy = rdy;
      v.exp_d = 16'(ed); v.exp_v = ev; v.exp_sa = 13'(esa); v.nm = nm;
      return v;
   endfunction

   function automatic logic [15:0] model_read(input int a);
      logic [15:0] st;
      st = '0;
      st[0] = (kq.size() != 0);
      st[1] = (sq.size() == 0);
      st[2] = (sq.size() == DEP);
      st[3] = sovf;
      st[4] = kovf;
      if (a < 16384)      return 16'(a) ^ 16'hC3C3;
      else if (a < KBD)   return 16'(a % 8192) ^ 16'h5A5A;
      else if (a == KBD)  return (kq.size() != 0) ? kq[0] : 16'h0000;
      else if (a == STAT) return st;
      else                return 16'h0000;
   endfunction

   task automatic model_reset();
      kq.delete();
      sq.delete();
      kovf = 0;
      sovf = 0;
   endtask

   // Applies one clock's worth of bus activity to the model.
   task automatic model_update();
      int  a;
      bit  kset, sset;
      a = int'(addr_i);
      kset = 0;
      sset = 0;
      if (load_i && a == KBD && kq.size() != 0) void'(kq.pop_front());
      if (kbd_valid_i) begin
         if (kq.size() < DEP) kq.push_back(kbd_code_i);
         else kset = 1;
      end
      if (scr_ready_i && sq.size() != 0) void'(sq.pop_front());
      if (load_i && a >= SCR && a < KBD) begin
         if (sq.size() < DEP) sq.push_back({addr_i[12:0], data_i});
         else sset = 1;
      end
      if (load_i && a == STAT) begin
         if (data_i[4]) kovf = 0;
         if (data_i[3]) sovf = 0;
      end
      if (kset) kovf = 1;
      if (sset) sovf = 1;
   endtask

   task automatic model_check();
      logic [28:0] h;
      h = (sq.size() != 0) ? sq[0] : 29'h0;
      chk("m_data", {16'h0, data_o}, {16'h0, model_read(int'(addr_i))});
      chk("m_valid", {31'h0, scr_valid_o}, {31'h0, sq.size() != 0});
      chk("m_scr_head", {3'h0, scr_addr_o, scr_data_o}, {3'h0, h});
      chk("m_ram_load", {31'h0, ram_load_o}, {31'h0, load_i && !addr_i[14]});
      chk("m_raddr", {19'h0, scr_raddr_o}, {19'h0, addr_i[12:0]});
   endtask

   task automatic drive(input bit ld, input int a, input int d, input bit kv,
                        input int kc, input bit rdy);
      load_i      = ld;
      addr_i      = 15'(a);
      data_i      = 16'(d);
      kbd_valid_i = kv;
      kbd_code_i  = 16'(kc);
      scr_ready_i = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_update();
      @(negedge clk_i);
   endtask

   initial begin
      reset_i = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;

      // ld, addr, data, kv, code, rdy, exp data_o, exp valid, exp scr_addr, name
      tbl.push_back(mk(0, KBD,  0, 0,  0, 0, 16'h0000, 0, 0, "rst_kbd"));
      tbl.push_back(mk(0, STAT, 0, 0,  0, 0, 16'h0002, 0, 0, "rst_stat"));
      tbl.push_back(mk(0, HOLE, 0, 0,  0, 0, 16'h0000, 0, 0, "rst_hole"));
      tbl.push_back(mk(0, KBD,  0, 1, 65, 0, 16'h0000, 0, 0, "kbd_not_yet"));
      tbl.push_back(mk(0, KBD,  0, 1, 66, 0, 65,       0, 0, "kbd_65"));
      tbl.push_back(mk(1, KBD,  0, 0,  0, 0, 65,       0, 0, "kbd_pop65"));
      tbl.push_back(mk(1, KBD,  0, 0,  0, 0, 66,       0, 0, "kbd_pop66"));
      tbl.push_back(mk(0, KBD,  0, 0,  0, 0, 0,        0, 0, "kbd_empty"));
      tbl.push_back(mk(0, STAT, 0, 0,  0, 0, 16'h0002, 0, 0, "stat_idle"));
      for (int i = 1; i <= 5; i++)
         tbl.push_back(mk(0, STAT, 0, 1, i, 0, (i == 1) ? 2 : 3, 0, 0, "kbd_fill"));
      tbl.push_back(mk(0, STAT, 0, 0,  0, 0, 16'h0013, 0, 0, "kbd_ovf"));
      tbl.push_back(mk(1, STAT, 16'h0010, 0, 0, 0, 16'h0013, 0, 0, "w1c_kovf"));
      tbl.push_back(mk(0, STAT, 0, 0,  0, 0, 16'h0003, 0, 0, "after_w1c"));
      for (int i = 1; i <= 4; i++)
         tbl.push_back(mk(1, KBD, 0, 0, 0, 0, i, 0, 0, "kbd_order"));
      tbl.push_back(mk(0, KBD,  0, 0,  0, 0, 0,        0, 0, "kbd_drained"));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1, SCR + i, 16'hAAAA, 0, 0, 0, 16'h5A5A ^ i, i != 0, 0, "scr_fill"));
      tbl.push_back(mk(0, STAT, 0, 0,  0, 0, 16'h000C, 1, 0, "scr_full_ovf"));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, HOLE, 0, 0, 0, 1, 0, 1, i, "scr_drain"));
      tbl.push_back(mk(0, STAT, 0, 0,  0, 1, 16'h000A, 0, 0, "scr_done"));
      tbl.push_back(mk(1, 100, 16'h1234, 0, 0, 0, 16'hC3A7, 0, 0, "ram_wr"));
      tbl.push_back(mk(0, STAT, 0, 0,  0, 0, 16'h000A, 0, 0, "ram_no_scr"));
      tbl.push_back(mk(0, 100,  0, 0,  0, 0, 16'hC3A7, 0, 0, "ram_rd"));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, STAT, 0, 1, 10 + i, 0, (i == 0) ? 16'h000A : 16'h000B, 0, 0, "kbd_fill2"));
      tbl.push_back(mk(1, KBD,  0, 1, 99, 0, 10,       0, 0, "kbd_pop_push"));
      tbl.push_back(mk(0, STAT, 0, 0,  0, 0, 16'h000B, 0, 0, "kbd_no_ovf"));
      tbl.push_back(mk(1, KBD,  0, 0,  0, 0, 11,       0, 0, "kbd_tail11"));
      tbl.push_back(mk(1, KBD,  0, 0,  0, 0, 12,       0, 0, "kbd_tail12"));
      tbl.push_back(mk(1, KBD,  0, 0,  0, 0, 13,       0, 0, "kbd_tail13"));
      tbl.push_back(mk(1, KBD,  0, 0,  0, 0, 99,       0, 0, "kbd_tail99"));
      tbl.push_back(mk(0, KBD,  0, 0,  0, 0, 0,        0, 0, "kbd_final"));

      foreach (tbl[i]) begin
         drive(tbl[i].ld, tbl[i].a, tbl[i].d, tbl[i].kv, tbl[i].kc, tbl[i].rdy);
         model_check();
         chk({tbl[i].nm, "_data"}, {16'h0, data_o}, {16'h0, tbl[i].exp_d});
         chk({tbl[i].nm, "_valid"}, {31'h0, scr_valid_o}, {31'h0, tbl[i].exp_v});
         if (tbl[i].exp_v) begin
            chk({tbl[i].nm, "_saddr"}, {19'h0, scr_addr_o}, {19'h0, tbl[i].exp_sa});
            chk({tbl[i].nm, "_sdata"}, {16'h0, scr_data_o}, 32'h0000AAAA);
         end
         tick();
      end

      // Reset asserted while the screen FIFO is draining.
      for (int i = 0; i < 3; i++) begin
         drive(1, SCR + 8 + i, 16'h1000 + i, 0, 0, 0);
         model_check();
         tick();
      end
      drive(0, STAT, 0, 0, 0, 1);
      model_check();
      @(posedge clk_i);
      model_update();
      #2;
      chk("pre_rst_valid", {31'h0, scr_valid_o}, 32'h1);
      reset_i = 1'b1;
      #1;
      chk("rstmid_valid", {31'h0, scr_valid_o}, 32'h0);
      chk("rstmid_stat", {16'h0, data_o}, 32'h0002);
      chk("rstmid_saddr", {19'h0, scr_addr_o}, 32'h0);
      model_reset();
      @(negedge clk_i);
      reset_i = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         int r, a;
         r = int'($urandom_range(0, 5));
         case (r)
            0:       a = int'($urandom_range(0, 16383));
            1, 2:    a = SCR + int'($urandom_range(0, 8191));
            3:       a = KBD;
            4:       a = STAT;
            default: a = int'($urandom_range(24578, 32767));
         endcase
         drive($urandom_range(0, 1) == 1, a, int'($urandom_range(0, 65535)),
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 65535)),
               $urandom_range(0, 2) != 0);
         model_check();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
